// File: rtl/deframer_pkg.sv
// deframer_pkg: shared FSM state type, default sync pattern and parity helper for serial_deframer
// No ports; imported by serial_deframer and deframer_out_slot.
package deframer_pkg;
  typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/deframer_out_slot.sv
// deframer_out_slot: single-entry valid/ready holding register with sticky overrun on a dropped load
// Ports: clk, rst_n (async, active-low); i_load/i_data offer a new entry; i_ready accepts o_data
//        when o_valid; i_clr_ovr clears o_overrun, which is set when a load finds the slot busy.
module deframer_out_slot import deframer_pkg::*; #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  input  logic         i_clr_ovr,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);
  logic [W-1:0] r_data;
  logic         r_valid, r_ovr;
  logic         w_take;
  // The slot can take a new entry when empty or when its current entry leaves this cycle.
  assign w_take    = i_load && (!r_valid || i_ready);
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_data  <= w_take ? i_data : r_data;
      r_valid <= w_take || (r_valid && !i_ready);
      r_ovr   <= (i_load && !w_take) || (r_ovr && !i_clr_ovr);
    end
  end
endmodule

// File: rtl/serial_deframer.sv
// serial_deframer: hunts a sync pattern in a serial stream, deserialises a word MSB-first and checks even parity
// Ports: clk, rst_n (async, active-low); sin/sin_en serial input and its qualifier;
//        dout/dout_perr/dout_valid/dout_ready output word port; locked while receiving a frame;
//        overrun sticky drop flag, cleared by clr_ovr.
module serial_deframer import deframer_pkg::*; #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC   = SYNC_W'(SYNC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_perr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              locked,
  output logic              overrun,
  input  logic              clr_ovr
);
  localparam int FW = $clog2(SYNC_W + 1);
  localparam int BW = $clog2(DATA_W + 1);
  state_t            r_state, w_state_nxt;
  logic [SYNC_W-1:0] r_sync_sr, w_win;
  logic [FW-1:0]     r_fill_cnt;
  logic [DATA_W-1:0] r_data_sr;
  logic [BW-1:0]     r_bit_cnt;
  logic              w_match, w_last, w_load, w_perr;
  logic [DATA_W:0]   w_slot_q;
  // Window including the current bit, so a match is recognised on the edge that delivers the last sync bit.
  assign w_win   = {r_sync_sr[SYNC_W-2:0], sin};
  assign w_match = (r_fill_cnt >= FW'(SYNC_W - 1)) && (w_win == SYNC);
  assign w_last  = r_bit_cnt == BW'(DATA_W - 1);
  assign w_load  = sin_en && (r_state == PAR);
  assign w_perr  = even_par(32'(r_data_sr)) ^ sin;
  assign locked  = (r_state == DATA) || (r_state == PAR);
  always_comb begin
    w_state_nxt = r_state;
    if (sin_en)
      w_state_nxt = (r_state == HUNT) ? (w_match ? DATA : HUNT) :
                    (r_state == DATA) ? (w_last ? PAR : DATA) : HUNT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end
  // Leaving PAR empties the hunt window so every frame needs a fresh, complete sync pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_sr  <= '0;
      r_fill_cnt <= '0;
      r_data_sr  <= '0;
      r_bit_cnt  <= '0;
    end else if (sin_en) begin
      if (r_state == HUNT) begin
        r_sync_sr  <= w_win;
        r_fill_cnt <= (r_fill_cnt == FW'(SYNC_W)) ? r_fill_cnt : r_fill_cnt + 1'b1;
        r_bit_cnt  <= '0;
      end else if (r_state == DATA) begin
        r_data_sr <= {r_data_sr[DATA_W-2:0], sin};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        r_sync_sr  <= '0;
        r_fill_cnt <= '0;
      end
    end
  end
  deframer_out_slot #(.W(DATA_W + 1)) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_data   ({r_data_sr, w_perr}),
    .i_ready  (dout_ready),
    .i_clr_ovr(clr_ovr),
    .o_data   (w_slot_q),
    .o_valid  (dout_valid),
    .o_overrun(overrun)
  );
  assign dout      = w_slot_q[DATA_W:1];
  assign dout_perr = w_slot_q[0];
endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: randomized and directed stimulus checked by a queue-based frame model and a scoreboard
module tb_serial_deframer;
  localparam int DW = 8;
  localparam int SW = 8;
  localparam logic [31:0] SYNC = 32'hA5;
  typedef struct packed {logic [DW-1:0] w; logic p;} exp_t;
  logic clk = 0, rst_n = 0, sin_en = 0, sin = 0, dout_ready = 0, clr_ovr = 0;
  logic [DW-1:0] dout;
  logic dout_perr, dout_valid, locked, overrun;
  int n_chk = 0, n_fail = 0, n_words = 0, rdy_mode = 1, w0;
  bit rnd_clr = 0;
  logic [DW-1:0] last_word = '0;
  exp_t sb[$];
  bit hq[$], cq[$];
  bit m_lock = 0, m_valid = 0, m_ovr = 0;
  always #5 clk = ~clk;
  serial_deframer dut (
    .clk(clk), .rst_n(rst_n), .sin_en(sin_en), .sin(sin),
    .dout(dout), .dout_perr(dout_perr), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .locked(locked), .overrun(overrun), .clr_ovr(clr_ovr)
  );
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction
  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = 0;
    for (int i = 0; i < q.size(); i++) v = (v << 1) | 32'(q[i]);
    return v;
  endfunction
  // Reference: last SW bits seen while hunting must equal SYNC; then the next DW+1 bits are word + parity.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hq.delete(); cq.delete(); sb.delete();
      m_lock = 0; m_valid = 0; m_ovr = 0;
    end else begin : model
      bit done;
      exp_t e;
      done = 0;
      e = '0;
      if (sin_en) begin
        if (!m_lock) begin
          hq.push_back(sin);
          if (hq.size() > SW) void'(hq.pop_front());
          if (hq.size() == SW && pack(hq) == SYNC) begin
            m_lock = 1;
            cq.delete();
          end
        end else begin
          cq.push_back(sin);
          if (cq.size() == DW + 1) begin
            for (int i = 0; i < DW; i++) e.w = {e.w[DW-2:0], cq[i]};
            e.p = (^e.w) ^ cq[DW];
            done = 1;
            m_lock = 0;
            hq.delete();
          end
        end
      end
      if (done && m_valid && !dout_ready) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
      if (done && (!m_valid || dout_ready)) sb.push_back(e);
      m_valid = done || (m_valid && !dout_ready);
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("valid", dout_valid, m_valid);
    chk("locked", locked, m_lock);
    chk("overrun", overrun, m_ovr);
    if (dout_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: got word %0h required none", dout);
      end else begin
        chk("dout", dout, sb[0].w);
        chk("perr", dout_perr, sb[0].p);
        if (dout_ready) begin
          void'(sb.pop_front());
          n_words++;
          last_word = dout;
        end
      end
    end
  end
  task automatic step(input bit en, input bit b);
    @(posedge clk); #1;
    sin_en = en; sin = b;
    dout_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    clr_ovr = rnd_clr && ($urandom_range(0, 7) == 0);
  endtask
  task automatic send_bits(input logic [31:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps && (i % 3 == 1)) repeat (2) step(0, 1'($urandom_range(0, 1)));
      step(1, v[i]);
    end
  endtask
  task automatic frame(input logic [7:0] d, input bit p, input bit gaps);
    send_bits({15'h0, 8'hA5, d, p}, 17, gaps);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 1'($urandom_range(0, 1)));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_perr", dout_perr, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overrun", overrun, 0);
    frame(8'h3C, 0, 0);
    step(0, 0);
    @(negedge clk);
    chk("t1_valid", dout_valid, 1);
    chk("t1_dout", dout, 32'h3C);
    chk("t1_perr", dout_perr, 0);
    frame(8'h3C, 1, 0);
    step(0, 0);
    @(negedge clk);
    chk("t2_dout", dout, 32'h3C);
    chk("t2_perr", dout_perr, 1);
    chk("t2_locked", locked, 0);
    rdy_mode = 0;
    idle(2);
    frame(8'h11, 0, 0);
    frame(8'h22, 0, 0);
    idle(2);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_dout", dout, 32'h11);
    rdy_mode = 1;
    idle(2);
    @(negedge clk);
    chk("ovr_drained", dout_valid, 0);
    chk("ovr_kept", overrun, 1);
    @(posedge clk); #1 clr_ovr = 1;
    @(posedge clk); #1 clr_ovr = 0;
    @(negedge clk);
    chk("ovr_clr", overrun, 0);
    w0 = n_words;
    send_bits(32'hA43C, 16, 0);
    for (int i = 0; i < 24; i++) step(1, 1'(i % 2));
    idle(1);
    @(negedge clk);
    chk("nm_words", n_words - w0, 0);
    w0 = n_words;
    frame(8'h3C, 0, 1);
    frame(8'hFF, 0, 0);
    idle(3);
    @(negedge clk);
    chk("gap_words", n_words - w0, 2);
    chk("gap_last", last_word, 32'hFF);
    send_bits(32'hA55, 12, 0);
    @(posedge clk); #1 rst_n = 0; sin_en = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("mid_rst_locked", locked, 0);
    w0 = n_words;
    frame(8'h5A, 0, 0);
    idle(3);
    @(negedge clk);
    chk("rst_words", n_words - w0, 1);
    chk("rst_last", last_word, 32'h5A);
    rdy_mode = 2;
    rnd_clr = 1;
    repeat (40) begin
      if ($urandom_range(0, 2) != 0) frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else repeat ($urandom_range(3, 20)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rnd_clr = 0;
    rdy_mode = 1;
    idle(4);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
